csi_tx_packet_framer: RTL and testbench

CSI-2 transmit-side packet framer: accepts a packet request (data type, virtual channel, word count) and an 8-bit payload stream, and emits a single byte stream of header, payload and footer. Short packets get a 4-byte header. Long packets get header, payload and a 2-byte CRC-16 footer. Header ECC uses the same 24-bit-in / 8-bit-out parity equations as the receive-side header ECC generator. The block sits upstream of the TX lane distributor and is the transmit counterpart of the CSI-2 RX header/packet path.

---
 rtl/csi_tx_packet_framer_if.sv | 31 +++
 rtl/csi_tx_packet_framer.sv | 224 ++++++++++++++++++++++
 tb/tb_csi_tx_packet_framer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csi_tx_packet_framer_if.sv
// Request, payload and output byte-stream signals of the CSI-2 TX packet framer.
// The master drives requests/payload and consumes bytes; the slave is the framer.
interface csi_tx_packet_framer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_dt;
    logic [1:0]  req_vc;
    logic [15:0] req_wc;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  din_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  dout_data;
    logic        dout_sop;
    logic        dout_eop;

    modport master (
        output req_valid, req_dt, req_vc, req_wc,
        output din_valid, din_data, dout_ready,
        input  req_ready, din_ready,
        input  dout_valid, dout_data, dout_sop, dout_eop
    );

    modport slave (
        input  req_valid, req_dt, req_vc, req_wc,
        input  din_valid, din_data, dout_ready,
        output req_ready, din_ready,
        output dout_valid, dout_data, dout_sop, dout_eop
    );
endinterface

// File: rtl/csi_tx_packet_framer.sv
// CSI-2 TX packet framer: header + ECC, payload pass-through, CRC-16 footer.
// Define CSI_TX_CRC_EN to compute the footer CRC; otherwise the footer is 0x0000.
module csi_tx_packet_framer (
    input  logic                         clk,
    input  logic                         rst_n,
    csi_tx_packet_framer_if.slave        bus,
    output logic                         busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CRC     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  dt_q, dt_d;
    logic [1:0]  vc_q, vc_d;
    logic [15:0] wc_q, wc_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        crc_idx_q, crc_idx_d;
    logic        last_q, last_d;
    logic        dout_valid_q, dout_valid_d;
    logic [7:0]  dout_data_q, dout_data_d;
    logic        dout_sop_q, dout_sop_d;
    logic        dout_eop_q, dout_eop_d;

    logic        adv;
    logic        is_short;
    logic [23:0] hdr_word;
    logic [7:0]  ecc;
    logic [7:0]  hdr_byte;
    logic [15:0] footer;

`ifdef CSI_TX_CRC_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
            else                c = c >> 1;
        end
        return c;
    endfunction

    assign footer = crc_q;
`else
    assign footer = 16'h0000;
`endif

    assign adv      = !dout_valid_q || bus.dout_ready;
    assign is_short = (dt_q[5:4] == 2'b00);
    assign hdr_word = {wc_q, vc_q, dt_q};

    // Each mask selects the header bits feeding one ECC parity bit.
    assign ecc = {2'b00,
                  ^(hdr_word & 24'hEFFC00),
                  ^(hdr_word & 24'hDF03F0),
                  ^(hdr_word & 24'hB8E38E),
                  ^(hdr_word & 24'h749A6D),
                  ^(hdr_word & 24'hF2555B),
                  ^(hdr_word & 24'hF12CB7)};

    always_comb begin
        case (hdr_idx_q)
            2'd0:    hdr_byte = {vc_q, dt_q};
            2'd1:    hdr_byte = wc_q[7:0];
            2'd2:    hdr_byte = wc_q[15:8];
            default: hdr_byte = ecc;
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.din_ready  = (state_q == S_PAYLOAD) && adv;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_data  = dout_data_q;
    assign bus.dout_sop   = dout_sop_q;
    assign bus.dout_eop   = dout_eop_q;
    assign busy           = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        dt_d         = dt_q;
        vc_d         = vc_q;
        wc_d         = wc_q;
        hdr_idx_d    = hdr_idx_q;
        cnt_d        = cnt_q;
        crc_idx_d    = crc_idx_q;
        last_d       = last_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_sop_d   = dout_sop_q;
        dout_eop_d   = dout_eop_q;
`ifdef CSI_TX_CRC_EN
        crc_d        = crc_q;
`endif
        // Output slot drains to empty unless a byte is loaded below.
        if (adv) dout_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                last_d = 1'b0;
                if (bus.req_valid) begin
                    dt_d    = bus.req_dt;
                    vc_d    = bus.req_vc;
                    wc_d    = bus.req_wc;
                    state_d = S_HDR;
`ifdef CSI_TX_CRC_EN
                    crc_d   = 16'hFFFF;
`endif
                    // Byte 0 needs no ECC, so it goes straight out when the slot is free.
                    if (adv) begin
                        dout_valid_d = 1'b1;
                        dout_data_d  = {bus.req_vc, bus.req_dt};
                        dout_sop_d   = 1'b1;
                        dout_eop_d   = 1'b0;
                        hdr_idx_d    = 2'd1;
                    end else begin
                        hdr_idx_d    = 2'd0;
                    end
                end
            end
            S_HDR: begin
                if (last_q) begin
                    state_d = S_IDLE;
                    last_d  = 1'b0;
                end else if (adv) begin
                    dout_valid_d = 1'b1;
                    dout_data_d  = hdr_byte;
                    dout_sop_d   = (hdr_idx_q == 2'd0);
                    dout_eop_d   = is_short && (hdr_idx_q == 2'd3);
                    hdr_idx_d    = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        if (is_short) begin
                            last_d = 1'b1;
                        end else if (wc_q == 16'd0) begin
                            state_d   = S_CRC;
                            crc_idx_d = 1'b0;
                        end else begin
                            state_d = S_PAYLOAD;
                            cnt_d   = wc_q;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.din_valid && adv) begin
                    dout_valid_d = 1'b1;
                    dout_data_d  = bus.din_data;
                    dout_sop_d   = 1'b0;
                    dout_eop_d   = 1'b0;
                    cnt_d        = cnt_q - 16'd1;
`ifdef CSI_TX_CRC_EN
                    crc_d        = crc16_byte(crc_q, bus.din_data);
`endif
                    if (cnt_q == 16'd1) begin
                        state_d   = S_CRC;
                        crc_idx_d = 1'b0;
                    end
                end
            end
            S_CRC: begin
                if (last_q) begin
                    state_d = S_IDLE;
                    last_d  = 1'b0;
                end else if (adv) begin
                    dout_valid_d = 1'b1;
                    dout_sop_d   = 1'b0;
                    if (!crc_idx_q) begin
                        dout_data_d = footer[7:0];
                        dout_eop_d  = 1'b0;
                        crc_idx_d   = 1'b1;
                    end else begin
                        dout_data_d = footer[15:8];
                        dout_eop_d  = 1'b1;
                        last_d      = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dt_q         <= '0;
            vc_q         <= '0;
            wc_q         <= '0;
            hdr_idx_q    <= '0;
            cnt_q        <= '0;
            crc_idx_q    <= 1'b0;
            last_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
`ifdef CSI_TX_CRC_EN
            crc_q        <= 16'hFFFF;
`endif
        end else begin
            state_q      <= state_d;
            dt_q         <= dt_d;
            vc_q         <= vc_d;
            wc_q         <= wc_d;
            hdr_idx_q    <= hdr_idx_d;
            cnt_q        <= cnt_d;
            crc_idx_q    <= crc_idx_d;
            last_q       <= last_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
`ifdef CSI_TX_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_csi_tx_packet_framer.sv
// Randomized bench for csi_tx_packet_framer against a byte-list reference model.
// Directed cases cover short/long/WC=0 packets, stalls, mid-packet reset and back-to-back requests.
module tb_csi_tx_packet_framer;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    csi_tx_packet_framer_if bus_if();

    csi_tx_packet_framer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned pay[$];
    logic [9:0]   exp_q[$];   // {sop, eop, data}
    logic [9:0]   got_q[$];

    byte unsigned vec24[24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                                8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                                8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_ecc(input logic [23:0] d);
        logic [7:0] e;
        e    = 8'h00;
        e[5] = (^d[19:10]) ^ d[21] ^ d[22] ^ d[23];
        e[4] = (^d[9:4]) ^ (^d[20:16]) ^ d[22] ^ d[23];
        e[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        e[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        e[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^ (^d[23:20]);
        e[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^ (^d[23:20]);
        return e;
    endfunction

    // Serial LFSR over the message bits, LSB of each byte first.
    function automatic logic [15:0] model_crc(input int n);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ pay[i][b];
                r  = {1'b0, r[15:1]};
                if (fb) begin
                    r[15] = ~r[15];
                    r[10] = ~r[10];
                    r[3]  = ~r[3];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] model_footer(input int n);
`ifdef CSI_TX_CRC_EN
        return model_crc(n);
`else
        return (n < 0) ? model_crc(0) : 16'h0000;
`endif
    endfunction

    // Appends the expected byte list of one packet to exp_q.
    task automatic build_expected(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
        logic [15:0] f;
        bit          short_pkt;
        short_pkt = (dt < 6'h10);
        exp_q.push_back({2'b10, vc, dt});
        exp_q.push_back({2'b00, wc[7:0]});
        exp_q.push_back({2'b00, wc[15:8]});
        exp_q.push_back({1'b0, short_pkt, model_ecc({wc, vc, dt})});
        if (!short_pkt) begin
            for (int i = 0; i < int'(wc); i++) exp_q.push_back({2'b00, pay[i]});
            f = model_footer(int'(wc));
            exp_q.push_back({2'b00, f[7:0]});
            exp_q.push_back({2'b01, f[15:8]});
        end
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i <= n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic send_packet(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                               input int rdy_pct, input int din_pct);
        int         n_pay, din_idx, extra, acc_cyc, sop_cyc, eop_cyc;
        bit         accepted, stalled, timed_out;
        logic [9:0] prev;
        n_pay = (dt < 6'h10) ? 0 : int'(wc);
        exp_q.delete();
        got_q.delete();
        build_expected(dt, vc, wc);
        din_idx = 0; extra = 0; acc_cyc = -1; sop_cyc = -1; eop_cyc = -1;
        accepted = 0; stalled = 0; timed_out = 1; prev = '0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            bus_if.req_valid  = !accepted;
            bus_if.req_dt     = dt;
            bus_if.req_vc     = vc;
            bus_if.req_wc     = wc;
            bus_if.dout_ready = (int'($urandom_range(99)) < rdy_pct);
            bus_if.din_valid  = (int'($urandom_range(99)) < din_pct);
            bus_if.din_data   = (din_idx < pay.size()) ? pay[din_idx] : 8'h00;
            #1;
            if (stalled)
                check("hold", {bus_if.dout_valid, bus_if.dout_sop, bus_if.dout_eop, bus_if.dout_data},
                      {1'b1, prev});
            stalled = bus_if.dout_valid && !bus_if.dout_ready;
            prev    = {bus_if.dout_sop, bus_if.dout_eop, bus_if.dout_data};
            if (bus_if.req_valid && bus_if.req_ready) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (bus_if.din_ready && din_idx >= n_pay) extra++;
            if (bus_if.din_valid && bus_if.din_ready) din_idx++;
            if (bus_if.dout_valid && bus_if.dout_ready) begin
                got_q.push_back({bus_if.dout_sop, bus_if.dout_eop, bus_if.dout_data});
                if (bus_if.dout_sop && sop_cyc < 0) sop_cyc = cyc;
                if (bus_if.dout_eop) eop_cyc = cyc;
                if (got_q.size() == exp_q.size()) begin
                    timed_out = 0;
                    break;
                end
            end
        end
        @(negedge clk);
        bus_if.req_valid  = 1'b0;
        bus_if.din_valid  = 1'b0;
        bus_if.dout_ready = 1'b1;
        #1;
        check("timeout", timed_out, 0);
        check("post_req_ready", bus_if.req_ready, 1);
        check("post_busy", busy, 0);
        check("post_dout_valid", bus_if.dout_valid, 0);
        check("nbytes", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        check("din_count", din_idx, n_pay);
        check("din_extra", extra, 0);
        if (rdy_pct == 100) check("latency", sop_cyc - acc_cyc, 1);
        if (rdy_pct == 100 && din_pct == 100) check("length", eop_cyc - sop_cyc + 1, exp_q.size());
        $display("pkt dt=%02h vc=%0d wc=%0d rdy=%0d din=%0d bytes=%0d", dt, vc, wc, rdy_pct, din_pct, got_q.size());
    endtask

    task automatic reset_mid_payload();
        int din_idx;
        bit accepted, reached;
        pay.delete();
        for (int i = 0; i < 24; i++) pay.push_back(vec24[i]);
        pay.push_back(8'h00);
        din_idx = 0; accepted = 0; reached = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            bus_if.req_valid  = !accepted;
            bus_if.req_dt     = 6'h2B;
            bus_if.req_vc     = 2'd1;
            bus_if.req_wc     = 16'd24;
            bus_if.dout_ready = 1'b1;
            bus_if.din_valid  = 1'b1;
            bus_if.din_data   = pay[din_idx];
            #1;
            if (bus_if.req_valid && bus_if.req_ready) accepted = 1;
            if (bus_if.din_valid && bus_if.din_ready) din_idx++;
            if (din_idx == 10) begin
                reached = 1;
                break;
            end
        end
        check("rst_reach", reached, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_dout_valid", bus_if.dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", bus_if.req_ready, 1);
        check("rst_din_ready", bus_if.din_ready, 0);
        $display("reset asserted during payload byte %0d", din_idx);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.din_valid = 1'b0;
    endtask

    task automatic back_to_back();
        int  n_acc, first_eop, second_sop, n_sop;
        bit  done;
        exp_q.delete();
        got_q.delete();
        build_expected(6'h01, 2'd2, 16'hA5C3);
        build_expected(6'h07, 2'd3, 16'h1234);
        n_acc = 0; first_eop = -1; second_sop = -1; n_sop = 0; done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus_if.req_valid  = (n_acc < 2);
            bus_if.req_dt     = (n_acc == 0) ? 6'h01 : 6'h07;
            bus_if.req_vc     = (n_acc == 0) ? 2'd2 : 2'd3;
            bus_if.req_wc     = (n_acc == 0) ? 16'hA5C3 : 16'h1234;
            bus_if.dout_ready = 1'b1;
            bus_if.din_valid  = 1'b0;
            #1;
            if (bus_if.req_valid && bus_if.req_ready) n_acc++;
            if (bus_if.dout_valid && bus_if.dout_ready) begin
                got_q.push_back({bus_if.dout_sop, bus_if.dout_eop, bus_if.dout_data});
                if (bus_if.dout_eop && first_eop < 0) first_eop = cyc;
                if (bus_if.dout_sop) begin
                    n_sop++;
                    if (n_sop == 2) second_sop = cyc;
                end
                if (got_q.size() == exp_q.size()) begin
                    done = 1;
                    break;
                end
            end
        end
        bus_if.req_valid = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_gap", second_sop - first_eop, 2);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("b2b_byte%0d", i), got_q[i], exp_q[i]);
        $display("back-to-back eop@%0d sop@%0d", first_eop, second_sop);
    endtask

    initial begin
        int pct[3] = '{100, 70, 40};
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [15:0] f;
        rst_n             = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_dt     = '0;
        bus_if.req_vc     = '0;
        bus_if.req_wc     = '0;
        bus_if.din_valid  = 1'b0;
        bus_if.din_data   = '0;
        bus_if.dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", bus_if.dout_valid, 0);
        check("rst_data", bus_if.dout_data, 0);
        check("rst_sop", bus_if.dout_sop, 0);
        check("rst_eop", bus_if.dout_eop, 0);
        check("rst_ready", bus_if.req_ready, 1);
        check("rst_din_rdy", bus_if.din_ready, 0);
        check("rst_bsy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_random(0);
        send_packet(6'h00, 2'd0, 16'h0001, 100, 100);
        if (got_q.size() >= 4) check("short_ecc", got_q[3][7:0], 8'h1A);

        pay.delete();
        for (int i = 0; i < 24; i++) pay.push_back(vec24[i]);
        pay.push_back(8'h00);
        send_packet(6'h2B, 2'd0, 16'd24, 100, 100);
`ifdef CSI_TX_CRC_EN
        f = 16'h00F0;
`else
        f = 16'h0000;
`endif
        if (got_q.size() == 30) begin
            check("footer_lo", got_q[28][7:0], f[7:0]);
            check("footer_hi", got_q[29][7:0], f[15:8]);
        end

        fill_random(0);
        send_packet(6'h2B, 2'd0, 16'd0, 100, 100);

        for (int r = 0; r < 3; r++) begin
            pay.delete();
            for (int i = 0; i < 24; i++) pay.push_back(vec24[i]);
            pay.push_back(8'h00);
            send_packet(6'h2B, 2'd0, 16'd24, 55, 55);
        end

        reset_mid_payload();
        fill_random(0);
        send_packet(6'h02, 2'd1, 16'h00FF, 100, 100);

        back_to_back();

        for (int r = 0; r < 40; r++) begin
            dt = 6'($urandom);
            if (dt < 6'h10) wc = 16'($urandom);
            else            wc = 16'($urandom_range(40));
            fill_random((dt < 6'h10) ? 0 : int'(wc));
            send_packet(dt, 2'($urandom), wc, pct[$urandom_range(2)], pct[$urandom_range(2)]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
